// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline: opcode constants, default widths and
// the memory-stage FSM state encoding.
package cpu_pkg;

  localparam int unsigned DBITS_DEFAULT               = 32;
  localparam int unsigned REG_INDEX_BIT_WIDTH_DEFAULT = 4;
  localparam int unsigned OP_W                        = 4;
  localparam int unsigned TO_CNT_W                    = 8;

  localparam logic [OP_W-1:0] OP_LW = 4'b1001;
  localparam logic [OP_W-1:0] OP_SW = 4'b0101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// Writeback pipeline register with bubble insert.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   load_i      - capture the bundle; when low only the write enable clears
//   result_i/rd_i/wr_i - incoming writeback bundle
//   result_o/rd_o/wr_o - registered writeback bundle
module mem_wb_reg #(
  parameter int unsigned DBITS = 32,
  parameter int unsigned RW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [DBITS-1:0] result_i,
  input  logic [RW-1:0]    rd_i,
  input  logic             wr_i,
  output logic [DBITS-1:0] result_o,
  output logic [RW-1:0]    rd_o,
  output logic             wr_o
);

  logic [DBITS-1:0] result_q;
  logic [RW-1:0]    rd_q;
  logic             wr_q;

  // Bubbles hold data/index and only drop the write enable, so no double write.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
    end else if (load_i) begin
      result_q <= result_i;
      rd_q     <= rd_i;
      wr_q     <= wr_i;
    end else begin
      wr_q     <= 1'b0;
    end
  end

  assign result_o = result_q;
  assign rd_o     = rd_q;
  assign wr_o     = wr_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: performs LW/SW over a req/ack bus, stalls upstream
// while an access is outstanding, abandons it after TIMEOUT_CYCLES and
// registers the writeback bundle.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   ME_op/ME_func/ME_result/ME_storeData/ME_rd/ME_wrReg - EX/MEM register
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack - data bus
//   stall                          - freeze upstream pipeline registers
//   bus_err                        - sticky access-timeout flag
//   WB_result/WB_rd/WB_wrReg       - registered writeback bundle
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DBITS               = DBITS_DEFAULT,
  parameter int unsigned REG_INDEX_BIT_WIDTH = REG_INDEX_BIT_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES      = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [OP_W-1:0]                ME_op,
  input  logic [OP_W-1:0]                ME_func,
  input  logic [DBITS-1:0]               ME_result,
  input  logic [DBITS-1:0]               ME_storeData,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] ME_rd,
  input  logic                           ME_wrReg,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [DBITS-1:0]               mem_addr,
  output logic [DBITS-1:0]               mem_wdata,
  input  logic [DBITS-1:0]               mem_rdata,
  input  logic                           mem_ack,
  output logic                           stall,
  output logic                           bus_err,
  output logic [DBITS-1:0]               WB_result,
  output logic [REG_INDEX_BIT_WIDTH-1:0] WB_rd,
  output logic                           WB_wrReg
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e          state_q, state_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic                bus_err_q, bus_err_d;
  logic                is_lw, is_sw, is_mem;
  logic                timeout_hit;
  logic                wb_load;
  logic [DBITS-1:0]    wb_result_d;
  logic                unused_func;

  // Function field plays no part in memory decode.
  assign unused_func = ^ME_func;

  assign is_lw  = (ME_op == OP_LW);
  assign is_sw  = (ME_op == OP_SW);
  assign is_mem = is_lw | is_sw;

  assign timeout_hit = (state_q == ST_WAIT) && !mem_ack && (cnt_q == TO_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    case (state_q)
      ST_IDLE: begin
        if (is_mem && !mem_ack) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          state_d   = ST_IDLE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; a same-cycle ack or the timeout releases the stall at once.
  always_comb begin
    mem_req = 1'b0;
    case (state_q)
      ST_IDLE: mem_req = is_mem;
      ST_WAIT: mem_req = 1'b1;
      default: mem_req = 1'b0;
    endcase
    stall = mem_req & !mem_ack & !timeout_hit;
  end

  // Bus fields are held stable by the upstream stall.
  assign mem_we    = is_sw;
  assign mem_addr  = ME_result;
  assign mem_wdata = ME_storeData;
  assign bus_err   = bus_err_q;

  // Stores and abandoned accesses complete as bubbles.
  assign wb_load     = !stall && !timeout_hit && !is_sw;
  assign wb_result_d = is_lw ? mem_rdata : ME_result;

  mem_wb_reg #(
    .DBITS (DBITS),
    .RW    (REG_INDEX_BIT_WIDTH)
  ) u_wb_reg (
    .clk      (clk),
    .reset    (reset),
    .load_i   (wb_load),
    .result_i (wb_result_d),
    .rd_i     (ME_rd),
    .wr_i     (ME_wrReg),
    .result_o (WB_result),
    .rd_o     (WB_rd),
    .wr_o     (WB_wrReg)
  );

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    ME_op, ME_func;
  logic [DW-1:0] ME_result, ME_storeData, mem_rdata;
  logic [RW-1:0] ME_rd;
  logic          ME_wrReg, mem_ack;
  logic          mem_req, mem_we, stall, bus_err, WB_wrReg;
  logic [DW-1:0] mem_addr, mem_wdata, WB_result;
  logic [RW-1:0] WB_rd;

  mem_stage #(.DBITS(DW), .REG_INDEX_BIT_WIDTH(RW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ME_op(ME_op), .ME_func(ME_func),
    .ME_result(ME_result), .ME_storeData(ME_storeData), .ME_rd(ME_rd),
    .ME_wrReg(ME_wrReg), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall(stall), .bus_err(bus_err),
    .WB_result(WB_result), .WB_rd(WB_rd), .WB_wrReg(WB_wrReg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] res, sdata, rdata;
    logic [RW-1:0] rd;
    logic          wr, ack;
    logic          e_req, e_we, e_stall;
    logic [DW-1:0] e_res;
    logic [RW-1:0] e_rd;
    logic          e_wr, e_chk_data;
  } vec_t;

  typedef struct {
    logic [DW-1:0] res;
    logic [RW-1:0] rd;
    logic          wr, chk_data;
  } wb_exp_t;

  wb_exp_t sb[$];
  int tests = 0;
  int failed = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [DW-1:0] res, input logic [DW-1:0] sd,
                       input logic [RW-1:0] rd, input logic wr, input logic ack,
                       input logic [DW-1:0] rdata);
    ME_op = op; ME_result = res; ME_storeData = sd; ME_rd = rd; ME_wrReg = wr;
    mem_ack = ack; mem_rdata = rdata; ME_func = 4'($urandom_range(15));
  endtask

  task automatic push(input logic [DW-1:0] res, input logic [RW-1:0] rd, input logic wr,
                      input logic chk_data);
    wb_exp_t e;
    e.res = res; e.rd = rd; e.wr = wr; e.chk_data = chk_data;
    sb.push_back(e);
  endtask

  // Advance one clock, then compare the writeback bundle against the scoreboard.
  task automatic tick();
    wb_exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("wb_wrReg", DW'(WB_wrReg), DW'(e.wr));
      if (e.chk_data) begin
        chk("wb_result", WB_result, e.res);
        chk("wb_rd", DW'(WB_rd), DW'(e.rd));
      end
    end
  endtask

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'b0000, 32'h1234, 32'h0,    32'h0,        4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234,     4'd3, 1'b1, 1'b1};
    vecs[1] = '{4'b0101, 32'h200,  32'hCAFE, 32'h0,        4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        4'd0, 1'b0, 1'b0};
    vecs[2] = '{4'b1001, 32'h300,  32'h0,    32'hA5A5,     4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5,     4'd7, 1'b1, 1'b1};
    vecs[3] = '{4'b0011, 32'h55,   32'h0,    32'h0,        4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h55,       4'd2, 1'b1, 1'b1};
    vecs[4] = '{4'b0000, 32'h66,   32'h0,    32'h0,        4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h66,       4'd4, 1'b0, 1'b1};
    vecs[5] = '{4'b1000, 32'h77,   32'h0,    32'hBAD,      4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h77,       4'd9, 1'b1, 1'b1};
    vecs[6] = '{4'b1001, 32'h304,  32'h0,    32'h1,        4'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1,        4'd1, 1'b0, 1'b1};
    vecs[7] = '{4'b1101, 32'hF00D, 32'h0,    32'h0,        4'd15,1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hF00D,     4'd15,1'b1, 1'b1};

    reset = 1'b1;
    drive(4'b0000, '0, '0, '0, 1'b0, 1'b0, '0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_wb_result", WB_result, 32'h0);
    chk("rst_wb_rd", DW'(WB_rd), 32'h0);
    chk("rst_wb_wrReg", DW'(WB_wrReg), 32'h0);
    chk("rst_bus_err", DW'(bus_err), 32'h0);
    chk("rst_stall", DW'(stall), 32'h0);

    // Single-cycle operations, memory ones with zero-wait ack, back to back.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].op, vecs[i].res, vecs[i].sdata, vecs[i].rd, vecs[i].wr, vecs[i].ack, vecs[i].rdata);
      #1;
      chk("vec_req", DW'(mem_req), DW'(vecs[i].e_req));
      chk("vec_stall", DW'(stall), DW'(vecs[i].e_stall));
      if (vecs[i].e_req) begin
        chk("vec_we", DW'(mem_we), DW'(vecs[i].e_we));
        chk("vec_addr", mem_addr, vecs[i].res);
        if (vecs[i].e_we) chk("vec_wdata", mem_wdata, vecs[i].sdata);
      end
      push(vecs[i].e_res, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_chk_data);
      tick();
    end

    // LW acked after three wait cycles.
    for (int k = 0; k < 4; k++) begin
      drive(4'b1001, 32'h100, 32'h0, 4'd6, 1'b1, (k == 3), (k == 3) ? 32'hDEADBEEF : 32'h0);
      #1;
      chk("lw_req", DW'(mem_req), 32'h1);
      chk("lw_stall", DW'(stall), DW'(k != 3));
      chk("lw_addr", mem_addr, 32'h100);
      if (k == 3) push(32'hDEADBEEF, 4'd6, 1'b1, 1'b1);
      else        push('0, '0, 1'b0, 1'b0);
      tick();
    end
    drive(4'b0000, 32'h42, 32'h0, 4'd1, 1'b0, 1'b0, '0);
    #1;
    chk("post_lw_req", DW'(mem_req), 32'h0);
    push(32'h42, 4'd1, 1'b0, 1'b1);
    tick();

    // LW never acked: abandoned after TO wait cycles.
    for (int k = 0; k <= int'(TO); k++) begin
      drive(4'b1001, 32'h400, 32'h0, 4'd8, 1'b1, 1'b0, '0);
      #1;
      chk("to_req", DW'(mem_req), 32'h1);
      chk("to_stall", DW'(stall), DW'(k < int'(TO)));
      if (k == int'(TO)) chk("to_err_before", DW'(bus_err), 32'h0);
      push('0, '0, 1'b0, 1'b0);
      tick();
    end
    chk("to_bus_err", DW'(bus_err), 32'h1);
    drive(4'b0000, 32'h99, 32'h0, 4'd2, 1'b1, 1'b0, '0);
    #1;
    chk("to_after_stall", DW'(stall), 32'h0);
    push(32'h99, 4'd2, 1'b1, 1'b1);
    tick();
    chk("to_err_sticky", DW'(bus_err), 32'h1);

    // Reset during the WAIT of an LW; a late ack afterwards is ignored.
    drive(4'b1001, 32'h500, 32'h0, 4'd5, 1'b1, 1'b0, '0);
    push('0, '0, 1'b0, 1'b0);
    tick();
    push('0, '0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_wb_result", WB_result, 32'h0);
    chk("mid_rst_wb_rd", DW'(WB_rd), 32'h0);
    chk("mid_rst_wb_wrReg", DW'(WB_wrReg), 32'h0);
    chk("mid_rst_bus_err", DW'(bus_err), 32'h0);
    reset = 1'b0;
    drive(4'b0000, 32'h11, 32'h0, 4'd3, 1'b1, 1'b1, 32'hBEEF);
    #1;
    chk("late_ack_req", DW'(mem_req), 32'h0);
    chk("late_ack_stall", DW'(stall), 32'h0);
    push(32'h11, 4'd3, 1'b1, 1'b1);
    tick();
    drive(4'b1001, 32'h600, 32'h0, 4'd4, 1'b1, 1'b0, '0);
    #1;
    chk("idle_after_rst_stall", DW'(stall), 32'h1);
    push('0, '0, 1'b0, 1'b0);
    tick();
    drive(4'b1001, 32'h600, 32'h0, 4'd4, 1'b1, 1'b1, 32'h600D);
    #1;
    chk("rst_then_ack_stall", DW'(stall), 32'h0);
    push(32'h600D, 4'd4, 1'b1, 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 32-bit in-order pipeline.
- Consumes the instruction held in the execute/memory pipeline register and performs LW/SW on the data bus with a req/ack handshake.
- Stalls upstream stages while an access is outstanding.
- Registers the writeback bundle (result, destination register, write enable) for the register-file write stage.

Parameters:
- DBITS, 32, data and address width.
- REG_INDEX_BIT_WIDTH, 4, register index width.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before the access is abandoned (range 1..255, 8-bit counter).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ME_op  input  4  opcode from the execute/memory register.
- ME_func  input  4  function field (unused for memory ops; passed to the decode check only).
- ME_result  input  DBITS  ALU result; this is the effective address for LW/SW.
- ME_storeData  input  DBITS  rs2 value for SW.
- ME_rd  input  REG_INDEX_BIT_WIDTH  destination register.
- ME_wrReg  input  1  register write enable.
- mem_req  output  1  bus request.
- mem_we  output  1  1 = store, 0 = load.
- mem_addr  output  DBITS  bus address.
- mem_wdata  output  DBITS  store data.
- mem_rdata  input  DBITS  load data; valid when mem_ack is high.
- mem_ack  input  1  bus completion; single-cycle pulse.
- stall  output  1  freeze the upstream pipeline registers (drive their wrt_en = !stall).
- bus_err  output  1  sticky timeout flag.
- WB_result  output  DBITS  writeback data.
- WB_rd  output  REG_INDEX_BIT_WIDTH  writeback register.
- WB_wrReg  output  1  writeback enable.

Behaviour:
- Decode:
  - is_lw = (ME_op == 4'b1001).
  - is_sw = (ME_op == 4'b0101).
  - is_mem = is_lw | is_sw.
  - Opcode constants come from the shared package.
- FSM states: IDLE, WAIT.
  - Reset enters IDLE.
  - IDLE: mem_req = is_mem. If is_mem and !mem_ack, go to WAIT and clear the timeout counter.
  - WAIT: mem_req = 1. On mem_ack, go to IDLE. Otherwise increment the counter.
  - Timeout: if the counter reaches TIMEOUT_CYCLES-1 without ack, go to IDLE, set bus_err, and complete the instruction as a bubble.
- Bus outputs:
  - mem_we = is_sw, mem_addr = ME_result, mem_wdata = ME_storeData.
  - These are combinational and stay stable for the whole request because upstream is stalled.
  - mem_addr, mem_wdata and mem_we are don't-care when mem_req = 0.
- stall = mem_req & !mem_ack & !timeout_hit.
  - This allows a zero-wait access (ack in the same cycle as the request) to finish in one cycle.
- WB register: loads every cycle.
  - While stall = 1: WB_wrReg <= 0. WB_result and WB_rd are held, giving a bubble with no double write.
  - Completing LW (ack): WB_result <= mem_rdata, WB_rd <= ME_rd, WB_wrReg <= ME_wrReg.
  - Completing SW (ack): WB_wrReg <= 0.
  - Non-memory op: WB_result <= ME_result, WB_rd <= ME_rd, WB_wrReg <= ME_wrReg. Latency is 1 cycle with no stall.
  - Timeout completion: WB_wrReg <= 0.
- mem_ack while mem_req = 0: ignored.
- bus_err is cleared only by reset.
- Reset (including mid-access):
  - FSM returns to IDLE; counter, WB_result, WB_rd, WB_wrReg and bus_err all go to 0.
  - mem_req follows the decode of the current inputs from the next cycle.
  - The abandoned bus transaction is not tracked.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants OP_LW = 4'b1001, OP_SW = 4'b0101;
  - FSM state encoding;
  - DBITS and REG_INDEX_BIT_WIDTH defaults.
- Optional sub-module: mem_wb_reg, the writeback pipeline register with bubble insert, built from the existing parameterised Register.

Test Plan:
- ALU op (ME_op = 4'b0000, result 0x1234, rd 3, wrReg 1), no stall -> next cycle WB_result = 0x1234, WB_rd = 3, WB_wrReg = 1; stall never high.
- LW addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> mem_req high for 4 cycles, stall high for 3, WB_wrReg = 0 during the stall, then WB_result = 0xDEADBEEF, WB_wrReg = 1 for one cycle.
- SW addr 0x200, data 0xCAFE, ack in the same cycle -> mem_we = 1, mem_wdata = 0xCAFE, stall = 0, WB_wrReg = 0 next cycle.
- LW followed by ALU op back-to-back, each with zero-wait ack -> two consecutive WB writes with correct data, no bubble.
- LW never acked, TIMEOUT_CYCLES = 8 -> stall drops after 8 request cycles, bus_err = 1 and stays 1, WB_wrReg = 0.
- reset asserted during the WAIT of an LW -> next cycle: state IDLE, all WB outputs 0, bus_err 0; a late ack is ignored.
